// File: rtl/wb_ram_arbiter_if.sv
// ---------------------------------------------------------------------------
// wb_ram_arbiter_if
//   Wishbone classic bus bundle used on all three sides of wb_ram_arbiter.
//   The same bundle describes a master link (bridge / DMA / debug) and the
//   link toward the RAM slave.
//
//   Signals (direction seen from the bus master):
//     adr    out  ADDR_WIDTH      address
//     dat_w  out  DATA_WIDTH      write data
//     sel    out  DATA_WIDTH/8    byte selects
//     we     out  1               write enable
//     cyc    out  1               cycle request
//     stb    out  1               strobe
//     dat_r  in   DATA_WIDTH      read data
//     ack    in   1               acknowledge
//     err    in   1               error
//
//   Modports:
//     master  drives the request side, receives the response side
//     slave   receives the request side, drives the response side
// ---------------------------------------------------------------------------
interface wb_ram_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  localparam int SEL_WIDTH = DATA_WIDTH / 8;

  logic [ADDR_WIDTH-1:0] adr;
  logic [DATA_WIDTH-1:0] dat_w;
  logic [DATA_WIDTH-1:0] dat_r;
  logic [SEL_WIDTH-1:0]  sel;
  logic                  we;
  logic                  cyc;
  logic                  stb;
  logic                  ack;
  logic                  err;

  modport master (
    output adr, dat_w, sel, we, cyc, stb,
    input  dat_r, ack, err
  );

  modport slave (
    input  adr, dat_w, sel, we, cyc, stb,
    output dat_r, ack, err
  );
endinterface

// File: rtl/wb_ram_arbiter.sv
// ---------------------------------------------------------------------------
// wb_ram_arbiter
//   Two-master Wishbone classic arbiter sharing one Wishbone RAM slave.
//   Master 0 is the AXI-lite-to-Wishbone bridge, master 1 a second on-chip
//   master (DMA, debug). Whole CYC-bounded cycles are granted with
//   round-robin fairness; one idle bus cycle always separates two grants.
//
//   Ports:
//     clk_i   in   1   Wishbone clock
//     rst_i   in   1   asynchronous reset, active high
//     m0      wb_ram_arbiter_if.slave   master 0 link
//     m1      wb_ram_arbiter_if.slave   master 1 link
//     s       wb_ram_arbiter_if.master  link to the RAM slave
//     gnt_o   out  2   one-hot current grant {m1,m0}; 2'b00 when idle
//
//   Optional feature (macro WB_ARB_TIMEOUT_EN):
//     Bus-hang watchdog. When a granted strobe stays unanswered for
//     TIMEOUT_CYCLES cycles the granted master receives a one-cycle err,
//     the slave cycle is dropped and the grant is released. Without the
//     macro no counter exists and err is a plain passthrough.
// ---------------------------------------------------------------------------
module wb_ram_arbiter #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  wb_ram_arbiter_if.slave         m0,
  wb_ram_arbiter_if.slave         m1,
  wb_ram_arbiter_if.master        s,
  output logic [1:0]              gnt_o
);

  localparam int SEL_WIDTH = DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  // Last-grant pointer: 1 = master 1 held the last grant.
  logic last_gnt;
  logic last_gnt_nxt;

  // High in the single cycle the watchdog fires (never high without the macro).
  logic timeout_hit;

  // Slave-side request mux
  logic [ADDR_WIDTH-1:0] adr_mux;
  logic [DATA_WIDTH-1:0] dat_w_mux;
  logic [SEL_WIDTH-1:0]  sel_mux;
  logic                  we_mux;
  logic                  cyc_mux;
  logic                  stb_mux;

  // Master-side response demux
  logic [DATA_WIDTH-1:0] m0_dat_r;
  logic                  m0_ack;
  logic                  m0_err;
  logic [DATA_WIDTH-1:0] m1_dat_r;
  logic                  m1_ack;
  logic                  m1_err;

  // A watchdog limit below 2 cannot work; such a configuration leaves this
  // named marker in the elaborated hierarchy so it is easy to spot.
  if (TIMEOUT_CYCLES < 2) begin : g_timeout_cycles_below_two
    logic marker;
    assign marker = 1'b1;
  end

  // ---------------------------------------------------------------------------
  // Arbitration state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state    <= IDLE;
      last_gnt <= 1'b1;
    end else begin
      state    <= state_nxt;
      last_gnt <= last_gnt_nxt;
    end
  end

  // Next-state logic. Requests are only sampled in IDLE, so a new grant
  // always costs one registered cycle and no cyc input reaches s.cyc
  // combinationally while idle.
  always_comb begin
    state_nxt    = state;
    last_gnt_nxt = last_gnt;
    case (state)
      IDLE: begin
        if (m0.cyc && m1.cyc) begin
          state_nxt = last_gnt ? GNT0 : GNT1;
        end else if (m0.cyc) begin
          state_nxt = GNT0;
        end else if (m1.cyc) begin
          state_nxt = GNT1;
        end
      end
      GNT0: begin
        if (!m0.cyc || timeout_hit) begin
          state_nxt    = IDLE;
          last_gnt_nxt = 1'b0;
        end
      end
      GNT1: begin
        if (!m1.cyc || timeout_hit) begin
          state_nxt    = IDLE;
          last_gnt_nxt = 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

`ifdef WB_ARB_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic             granted_req;
  logic             stall;
  logic [CNT_W-1:0] wd_cnt;

  // Stall is taken from the granted master's request rather than from the
  // s outputs, which are themselves forced low by timeout_hit.
  always_comb begin
    granted_req = 1'b0;
    case (state)
      GNT0:    granted_req = m0.cyc & m0.stb;
      GNT1:    granted_req = m1.cyc & m1.stb;
      default: granted_req = 1'b0;
    endcase
  end

  assign stall       = granted_req & ~s.ack & ~s.err;
  // The counter holds the number of stalled cycles already seen, so the
  // TIMEOUT_CYCLES-th stalled cycle is the one that fires.
  assign timeout_hit = stall && (wd_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  // ---------------------------------------------------------------------------
  // Watchdog counter
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wd_cnt <= '0;
    end else if (state == IDLE || s.ack || s.err || timeout_hit) begin
      wd_cnt <= '0;
    end else if (stall) begin
      wd_cnt <= wd_cnt + 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // Bus mux driven purely from the registered state. Responses are gated
  // with the owner's cyc so an ack arriving after an abort never reaches
  // the master; the non-granted master always sees zeros.
  always_comb begin
    adr_mux   = '0;
    dat_w_mux = '0;
    sel_mux   = '0;
    we_mux    = 1'b0;
    cyc_mux   = 1'b0;
    stb_mux   = 1'b0;
    m0_dat_r  = '0;
    m0_ack    = 1'b0;
    m0_err    = 1'b0;
    m1_dat_r  = '0;
    m1_ack    = 1'b0;
    m1_err    = 1'b0;
    case (state)
      GNT0: begin
        adr_mux   = m0.adr;
        dat_w_mux = m0.dat_w;
        sel_mux   = m0.sel;
        we_mux    = m0.we;
        cyc_mux   = m0.cyc & ~timeout_hit;
        stb_mux   = m0.stb & ~timeout_hit;
        m0_dat_r  = s.dat_r;
        m0_ack    = s.ack & m0.cyc;
        m0_err    = (s.err & m0.cyc) | timeout_hit;
      end
      GNT1: begin
        adr_mux   = m1.adr;
        dat_w_mux = m1.dat_w;
        sel_mux   = m1.sel;
        we_mux    = m1.we;
        cyc_mux   = m1.cyc & ~timeout_hit;
        stb_mux   = m1.stb & ~timeout_hit;
        m1_dat_r  = s.dat_r;
        m1_ack    = s.ack & m1.cyc;
        m1_err    = (s.err & m1.cyc) | timeout_hit;
      end
      default: begin
      end
    endcase
  end

  always_comb begin
    gnt_o = 2'b00;
    case (state)
      GNT0:    gnt_o = 2'b01;
      GNT1:    gnt_o = 2'b10;
      default: gnt_o = 2'b00;
    endcase
  end

  assign s.adr    = adr_mux;
  assign s.dat_w  = dat_w_mux;
  assign s.sel    = sel_mux;
  assign s.we     = we_mux;
  assign s.cyc    = cyc_mux;
  assign s.stb    = stb_mux;

  assign m0.dat_r = m0_dat_r;
  assign m0.ack   = m0_ack;
  assign m0.err   = m0_err;
  assign m1.dat_r = m1_dat_r;
  assign m1.ack   = m1_ack;
  assign m1.err   = m1_err;

endmodule
